// File: rtl/uart_memdump_if.sv
// Memory read port and UART byte stream of the dump engine.
// master = dump engine, slave = memory / transmitter side.
`timescale 1ns/1ps
interface uart_memdump_if;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  tx_byte;
  logic        mem_ren;
  logic [31:0] mem_addr;
  logic [31:0] mem_rdata;

  modport master (
    output tx_valid, tx_byte, mem_ren, mem_addr,
    input  tx_ready, mem_rdata
  );

  modport slave (
    input  tx_valid, tx_byte, mem_ren, mem_addr,
    output tx_ready, mem_rdata
  );
endinterface

// File: rtl/uart_memdump.sv
// Memory readback over UART: AA header, base, length, then data words.
// One word in flight at a time, bytes sent LSB first.
`timescale 1ns/1ps
module uart_memdump #(
  parameter int         MEM_LATENCY = 2,
  parameter logic [7:0] START_BYTE  = 8'hAA
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dump_start,
  input  logic [31:0] dump_addr,
  input  logic [31:0] dump_len,
  output logic        dump_busy,
  output logic        dump_done,
  uart_memdump_if.master bus
);

  localparam int LW = $clog2(MEM_LATENCY + 1);
  localparam logic [LW-1:0] LAT_LAST = LW'(MEM_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE, HEADER, ADDRESS, LENGTH,
    READ, WAIT, STREAM, DONE
  } state_t;

  state_t        state_q, state_d;
  logic [31:0]   base_q, len_q, word_q;
  logic [29:0]   widx_q;
  logic [1:0]    bcnt_q;
  logic [LW-1:0] lat_q;

  logic          tx_valid, mem_ren, fire, last_b;
  logic [7:0]    tx_byte;
  logic [31:0]   mem_addr;
  logic [29:0]   nwords;

  function automatic logic [7:0] pick(
    input logic [31:0] v,
    input logic [1:0]  i
  );
    return v[{i, 3'b000} +: 8];
  endfunction

  assign nwords = len_q[31:2];
  assign last_b = (bcnt_q == 2'd3);

  assign bus.tx_valid = tx_valid;
  assign bus.tx_byte  = tx_byte;
  assign bus.mem_ren  = mem_ren;
  assign bus.mem_addr = mem_addr;

  always_comb begin
    state_d   = state_q;
    tx_valid  = 1'b0;
    tx_byte   = 8'h00;
    mem_ren   = 1'b0;
    mem_addr  = 32'h0;
    dump_busy = 1'b1;
    dump_done = 1'b0;
    unique case (state_q)
      IDLE: begin
        dump_busy = 1'b0;
        if (dump_start) state_d = HEADER;
      end
      HEADER: begin
        tx_valid = 1'b1;
        tx_byte  = START_BYTE;
        if (bus.tx_ready) state_d = ADDRESS;
      end
      ADDRESS: begin
        tx_valid = 1'b1;
        tx_byte  = pick(base_q, bcnt_q);
        if (bus.tx_ready && last_b) state_d = LENGTH;
      end
      LENGTH: begin
        tx_valid = 1'b1;
        tx_byte  = pick(len_q, bcnt_q);
        if (bus.tx_ready && last_b)
          state_d = (nwords == 30'd0) ? DONE : READ;
      end
      READ: begin
        mem_ren  = 1'b1;
        mem_addr = {2'b00, base_q[31:2]} + {2'b00, widx_q};
        state_d  = WAIT;
      end
      WAIT: begin
        if (lat_q == LAT_LAST) state_d = STREAM;
      end
      STREAM: begin
        tx_valid = 1'b1;
        tx_byte  = pick(word_q, bcnt_q);
        if (bus.tx_ready && last_b)
          state_d = (widx_q + 30'd1 == nwords) ? DONE : READ;
      end
      DONE: begin
        dump_busy = 1'b0;
        dump_done = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    fire = tx_valid && bus.tx_ready;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q <= '0;
      len_q  <= '0;
      word_q <= '0;
      widx_q <= '0;
      bcnt_q <= '0;
      lat_q  <= '0;
    end else begin
      if (state_q == IDLE && dump_start) begin
        base_q <= dump_addr & ~32'h3;
        len_q  <= dump_len & ~32'h3;
        widx_q <= '0;
        bcnt_q <= '0;
      end
      // START_BYTE is a single byte, so the byte counter stays at 0 there
      if (fire && state_q != HEADER) bcnt_q <= bcnt_q + 2'd1;
      if (fire && state_q == STREAM && last_b) widx_q <= widx_q + 30'd1;
      if (state_q == READ) lat_q <= '0;
      if (state_q == WAIT) begin
        lat_q <= lat_q + LW'(1);
        if (lat_q == LAT_LAST) word_q <= bus.mem_rdata;
      end
    end
  end

endmodule
